demux_sel_sequencer: RTL and testbench
======================================

// Module: demux_sel_sequencer
// PURPOSE
// Upstream driver for the 1x4 demux (demux_1x4).
// Accepts a serial data stream over a valid/ready handshake.
// Presents each accepted bit on din, with a registered channel select s that walks round-robin over enabled channels.
// Holds each channel for DWELL accepted beats, then moves to the next enabled channel.
// Flags the end of every full round-robin frame.
// PARAMETERS
// DWELL   4   accepted beats per channel visit (>=1; counter width $clog2(DWELL+1))
// PORTS
// clk        in   1  rising-edge clock
// rst        in   1  synchronous reset, active-high
// en         in   1  sequencer enable
// ch_mask    in   4  channel enable mask, bit i = demux output di
// in_valid   in   1  upstream data valid
// in_data    in   1  upstream data bit
// in_ready   out  1  sequencer accepts in_data this cycle
// din        out  1  registered data to demux din
// s          out  2  registered select to demux s
// out_valid  out  1  din holds a fresh beat this cycle (1-cycle pulse)
// frame_done out  1  1-cycle pulse: last beat of the frame's final channel
// busy       out  1  state != IDLE
// BEHAVIOUR
// - Reset (rst=1 at clk edge) puts the block in a known state:
//   state=IDLE, ptr=0, s=0, din=0, beat_cnt=0, out_valid=0, frame_done=0, in_ready=0.
// - rst overrides everything, including mid-DWELL; no beat is emitted on the reset cycle.
// - FSM IDLE -> SEEK when en=1 and ch_mask!=0; otherwise stays IDLE.
// - SEEK (1 cycle, in_ready=0):
//   - Search ch_mask cyclically starting at ptr; the first set bit k is the channel.
//   - Load s<=k and beat_cnt<=0, then go to DWELL.
//   - If ch_mask==0, go to IDLE and leave s unchanged.
//   - ch_mask is sampled only in SEEK; changes during DWELL take effect at the next SEEK.
// - DWELL: in_ready=1.
//   - A beat is accepted when in_valid & in_ready; then din<=in_data, out_valid<=1 next cycle, beat_cnt++.
//   - Cycles without in_valid do not count toward the dwell.
//   - On the DWELL-th accepted beat: ptr<=(s+1) mod 4.
//   - Then go to SEEK if en=1, else IDLE (en low mid-dwell still completes the current dwell).
// - Latency: accepted beat at edge t -> din/out_valid valid in cycle t+1.
// - s never changes while out_valid=1 for its channel's beats.
//   s only updates on SEEK->DWELL, so the final beat's out_valid cycle (SEEK) still shows the old s.
// - frame_done:
//   - Let n be the first set bit of the current ch_mask searching cyclically from s+1.
//   - frame_done pulses in the same cycle as out_valid for the final dwell beat when n<=s.
//   - It also pulses when ch_mask==0 at that point.
//   - With one enabled channel, it pulses every dwell.
// - din is held between beats (out_valid=0); the demux sees a stable din.
// - ptr wraps 3->0; s is always a 2-bit channel index.
// TESTING
// - rst=1 for 2 cycles:
//   s=0, din=0, out_valid=0, frame_done=0, in_ready=0, busy=0.
// - DWELL=4, ch_mask=1111, en=1, in_valid=1, in_data=1010... :
//   s=0,1,2,3 for 4 out_valid beats each, SEEK gap of 1 cycle with in_ready=0.
//   frame_done high with the 16th out_valid only.
// - ch_mask=1010: s alternates 1,3,1,3; frame_done pulses on the last beat at s=3 only.
// - in_valid toggling every other cycle:
//   each channel still gets exactly 4 out_valid beats, taking 8 cycles of DWELL.
// - ch_mask=0000 with en=1: stays IDLE, busy=0, in_ready=0.
//   en dropped after beat 2 of channel 1: beats 3-4 complete, then IDLE.
// - rst asserted mid-DWELL at s=2:
//   next cycle all outputs at reset values; after rst release, first channel is 0.

Source files
------------

// File: rtl/demux_sel_sequencer.sv
// demux_sel_sequencer: round-robin channel select and data sequencer feeding a 1x4 demux
module demux_sel_sequencer #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] ch_mask,
  input  logic       in_valid,
  input  logic       in_data,
  output logic       in_ready,
  output logic       din,
  output logic [1:0] s,
  output logic       out_valid,
  output logic       frame_done,
  output logic       busy
);
  localparam int CW = $clog2(DWELL + 1);
  typedef enum logic [1:0] {IDLE, SEEK, DW} state_t;
  state_t state, state_n;
  logic [1:0] ptr, k, n;
  logic [CW-1:0] beat_cnt;
  logic acc, last, fd_n;
  function automatic logic [1:0] first_set(input logic [3:0] m, input logic [1:0] st);
    logic [1:0] r;
    r = st;
    for (int i = 3; i >= 0; i--) if (m[st + 2'(i)]) r = st + 2'(i);
    return r;
  endfunction
  assign in_ready = state == DW;
  assign busy = state != IDLE;
  // next state, beat acceptance and end-of-frame detection
  always_comb begin
    acc = in_valid & in_ready;
    last = acc && beat_cnt == CW'(DWELL - 1);
    k = first_set(ch_mask, ptr);
    n = first_set(ch_mask, s + 2'd1);
    fd_n = last && (ch_mask == 4'd0 || n <= s);
    state_n = state == IDLE ? ((en && |ch_mask) ? SEEK : IDLE) :
              state == SEEK ? (|ch_mask ? DW : IDLE) :
              last ? (en ? SEEK : IDLE) : DW;
  end
  // state, select, data and pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      s <= '0;
      din <= 1'b0;
      beat_cnt <= '0;
      out_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      out_valid <= acc;
      frame_done <= fd_n;
      if (acc) begin
        din <= in_data;
        beat_cnt <= beat_cnt + CW'(1);
      end
      if (last) ptr <= s + 2'd1;
      if (state == SEEK && |ch_mask) begin
        s <= k;
        beat_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_demux_sel_sequencer.sv
// tb_demux_sel_sequencer: directed checks of select walk, framing, stalls, enable drop and reset
module tb_demux_sel_sequencer;
  logic clk = 1'b0;
  logic rst, en, in_valid, in_data;
  logic [3:0] ch_mask;
  logic in_ready, din, out_valid, frame_done, busy;
  logic [1:0] s;
  int n_chk = 0, n_fail = 0;
  int cyc, acc_cnt, nrec, fd_cnt, drop_at;
  bit toggle;
  int rs[64], rd[64], rf[64], rr[64], rc[64];
  demux_sel_sequencer #(.DWELL(4)) dut (
    .clk(clk), .rst(rst), .en(en), .ch_mask(ch_mask), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .din(din), .s(s), .out_valid(out_valid), .frame_done(frame_done), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic clear();
    for (int i = 0; i < 64; i++) begin
      rs[i] = -1; rd[i] = -1; rf[i] = -1; rr[i] = -1; rc[i] = -1;
    end
    nrec = 0; cyc = 0; acc_cnt = 0; fd_cnt = 0; drop_at = -1; toggle = 0;
  endtask
  task automatic step();
    @(negedge clk);
    cyc++;
    if (frame_done) fd_cnt++;
    if (out_valid && nrec < 64) begin
      rs[nrec] = s; rd[nrec] = din; rf[nrec] = frame_done; rr[nrec] = in_ready; rc[nrec] = cyc;
      nrec++;
    end
    in_data = ~acc_cnt[0];
    in_valid = toggle ? cyc[0] : 1'b1;
    if (acc_cnt == drop_at) en = 1'b0;
    if (in_valid && in_ready) acc_cnt++;
  endtask
  task automatic do_reset();
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear();
  endtask
  initial begin
    ch_mask = 4'b0000;
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("rst_s", s, 0);
    check("rst_din", din, 0);
    check("rst_ov", out_valid, 0);
    check("rst_fd", frame_done, 0);
    check("rst_rdy", in_ready, 0);
    check("rst_busy", busy, 0);
    // all four channels, continuous valid
    do_reset();
    ch_mask = 4'b1111; en = 1'b1;
    repeat (30) step();
    for (int j = 0; j < 16; j++) begin
      check($sformatf("all_s%0d", j), rs[j], j / 4);
      check($sformatf("all_din%0d", j), rd[j], (j % 2 == 0) ? 1 : 0);
      check($sformatf("all_fd%0d", j), rf[j], (j == 15) ? 1 : 0);
      check($sformatf("all_rdy%0d", j), rr[j], (j % 4 == 3) ? 0 : 1);
    end
    check("all_fdcnt", fd_cnt, 1);
    // channels 1 and 3
    do_reset();
    ch_mask = 4'b1010; en = 1'b1;
    repeat (24) step();
    for (int j = 0; j < 16; j++) begin
      check($sformatf("alt_s%0d", j), rs[j], ((j / 4) % 2 == 0) ? 1 : 3);
      check($sformatf("alt_fd%0d", j), rf[j], (j == 7 || j == 15) ? 1 : 0);
    end
    check("alt_fdcnt", fd_cnt, 2);
    // stalled input: beats every other cycle
    do_reset();
    ch_mask = 4'b1111; en = 1'b1; toggle = 1;
    repeat (30) step();
    for (int j = 0; j < 8; j++) check($sformatf("tog_s%0d", j), rs[j], j / 4);
    check("tog_gap01", rc[1] - rc[0], 2);
    check("tog_gap23", rc[3] - rc[2], 2);
    check("tog_gap45", rc[5] - rc[4], 2);
    // empty mask never leaves idle
    do_reset();
    ch_mask = 4'b0000; en = 1'b1;
    repeat (6) step();
    check("empty_busy", busy, 0);
    check("empty_rdy", in_ready, 0);
    check("empty_beats", nrec, 0);
    // enable dropped mid-dwell on channel 1
    do_reset();
    ch_mask = 4'b0010; en = 1'b1; drop_at = 2;
    repeat (20) step();
    check("drop_beats", nrec, 4);
    for (int j = 0; j < 4; j++) check($sformatf("drop_s%0d", j), rs[j], 1);
    check("drop_fd", rf[3], 1);
    check("drop_busy", busy, 0);
    check("drop_rdy", in_ready, 0);
    // reset in the middle of channel 2
    do_reset();
    ch_mask = 4'b1111; en = 1'b1;
    for (int b = 0; b < 200 && acc_cnt < 10; b++) step();
    check("mid_acc", acc_cnt, 10);
    check("mid_s", s, 2);
    check("mid_rdy", in_ready, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_s", s, 0);
    check("mid_rst_din", din, 0);
    check("mid_rst_ov", out_valid, 0);
    check("mid_rst_fd", frame_done, 0);
    check("mid_rst_rdy", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    rst = 1'b0;
    clear();
    repeat (10) step();
    check("mid_after_s", rs[0], 0);
    check("mid_after_din", rd[0], 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
